instruction_memory: RTL and testbench

- Byte-addressed, word-organised instruction store for the RV32 base core; feeds the fetch stage.
- Read path is purely combinational: the instruction appears on o_inst in the same cycle as i_addr.
- A synchronous write port lets a loader or bench overwrite program words.
- Asynchronous reset restores the built-in boot program.

---
 rtl/rv32_pkg.sv | 36 +++
 rtl/instruction_memory.sv | 63 ++++++
 tb/tb_instruction_memory.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32 definitions: instruction width, the built-in boot program
// and a few encodings that the fetch/decode pipeline relies on.
package rv32_pkg;

  localparam int INST_WIDTH = 32;
  localparam int BOOT_WORDS = 4;

  typedef logic [INST_WIDTH-1:0] inst_t;

  // Boot program, element [0] is the word at byte address 0.
  //   0x000 addi x2,x1,1
  //   0x004 addi x3,x1,1
  //   0x008 add  x4,x2,x3
  //   0x00C beq  x3,x2,-12
  localparam logic [BOOT_WORDS-1:0][INST_WIDTH-1:0] BOOT_IMAGE = {
    32'hfe218ae3,
    32'h00310233,
    32'h00108193,
    32'h00108113
  };

  // Canonical NOP (addi x0,x0,0) for pipeline bubbles.
  localparam inst_t NOP = 32'h00000013;

  // Reset value of a memory word: boot image inside the first four words,
  // zero everywhere else.
  function automatic inst_t boot_word(input int unsigned idx);
    inst_t word;
    word = '0;
    if (idx < BOOT_WORDS) begin
      word = BOOT_IMAGE[idx[1:0]];
    end
    return word;
  endfunction

endpackage

// File: rtl/instruction_memory.sv
// Word-organised, byte-addressed instruction store for the RV32 fetch stage.
// Reads are purely combinational; a single full-word write port updates the
// store on the rising clock edge. Reset reloads the boot program
// asynchronously, so every word is a plain register with its own reset value
// rather than an inferred RAM. MEM_SIZE must be a power of two, >= 16.
module instruction_memory
  import rv32_pkg::*;
#(
  parameter int MEM_SIZE = 1024,
  parameter int ADDR_W   = $clog2(MEM_SIZE)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [ADDR_W-1:0]     i_addr,
  output logic [INST_WIDTH-1:0] o_inst,
  output logic                  o_misaligned,
  input  logic                  i_we,
  input  logic [ADDR_W-1:0]     i_waddr,
  input  logic [INST_WIDTH-1:0] i_wdata
);

  localparam int NUM_WORDS = MEM_SIZE / 4;
  localparam int WORD_W    = ADDR_W - 2;

  logic [INST_WIDTH-1:0] mem_words [NUM_WORDS];
  logic [WORD_W-1:0]     rd_idx;
  logic [WORD_W-1:0]     wr_idx;

  // Byte-offset bits play no part in word selection for writes.
  logic unused_waddr_lsb;
  assign unused_waddr_lsb = ^i_waddr[1:0];

  assign rd_idx = i_addr[ADDR_W-1:2];
  assign wr_idx = i_waddr[ADDR_W-1:2];

  // One register per word so each can carry its own boot value on reset.
  // Reset dominates, so writes presented during reset are dropped.
  for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_word
    localparam inst_t RESET_VAL = boot_word(gi);

    logic [INST_WIDTH-1:0] word_reg;
    logic                  word_we;

    assign word_we = i_we && (wr_idx == WORD_W'(gi));

    // Async boot-image load, otherwise capture write data when addressed.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        word_reg <= RESET_VAL;
      end else if (word_we) begin
        word_reg <= i_wdata;
      end
    end

    assign mem_words[gi] = word_reg;
  end

  // Zero-latency read; there is no write bypass, so a same-word write only
  // shows up once the clock edge has committed it.
  assign o_inst       = mem_words[rd_idx];
  assign o_misaligned = |i_addr[1:0];

endmodule

// File: tb/tb_instruction_memory.sv
// Self-checking bench for instruction_memory. Expected values are pushed on a
// scoreboard queue as stimulus is applied and popped when the output is
// sampled.
module tb_instruction_memory;

  localparam int MEM_SIZE = 1024;
  localparam int ADDR_W   = 10;

  logic              i_clk;
  logic              i_rst_n;
  logic [ADDR_W-1:0] i_addr;
  logic [31:0]       o_inst;
  logic              o_misaligned;
  logic              i_we;
  logic [ADDR_W-1:0] i_waddr;
  logic [31:0]       i_wdata;

  instruction_memory #(.MEM_SIZE(MEM_SIZE)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_addr      (i_addr),
    .o_inst      (o_inst),
    .o_misaligned(o_misaligned),
    .i_we        (i_we),
    .i_waddr     (i_waddr),
    .i_wdata     (i_wdata)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s val=%08h t=%0t", tag, got, $time);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop_check(input logic [31:0] got);
    exp_t e;
    if (sb_q.size() == 0) begin
      failures++;
      checks++;
      $display("FAIL scoreboard_empty got=%08h exp=<none>", got);
    end else begin
      e = sb_q.pop_front();
      check_eq(e.tag, got, e.exp);
    end
  endtask

  // Present a read address, let it settle 10 time units, compare o_inst.
  task automatic read_expect(input string tag, input logic [ADDR_W-1:0] addr,
                             input logic [31:0] exp);
    sb_push(tag, exp);
    i_addr = addr;
    #10;
    sb_pop_check(o_inst);
  endtask

  task automatic write_word(input logic [ADDR_W-1:0] addr, input logic [31:0] data);
    @(negedge i_clk);
    i_we    = 1'b1;
    i_waddr = addr;
    i_wdata = data;
    @(posedge i_clk);
    #1;
    i_we = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    i_rst_n = 1'b1;
    i_we    = 1'b0;
    i_addr  = '0;
    i_waddr = '0;
    i_wdata = '0;

    // Reset pulse right at start of time.
    #1 i_rst_n = 1'b0;
    #1;
    read_expect("rst_hold_w0", 10'h000, 32'h00108113);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // Boot image through the combinational read path.
    read_expect("boot_w0", 10'h000, 32'h00108113);
    read_expect("boot_w1", 10'h004, 32'h00108193);
    read_expect("boot_w2", 10'h008, 32'h00310233);
    read_expect("boot_w3", 10'h00C, 32'hfe218ae3);
    read_expect("boot_w4", 10'h010, 32'h00000000);
    read_expect("boot_last", 10'h3FC, 32'h00000000);

    // Misaligned reads still return the truncated-index word.
    read_expect("misal_inst", 10'h006, 32'h00108193);
    sb_push("misal_flag_6", 32'd1);
    sb_pop_check({31'd0, o_misaligned});
    i_addr = 10'h003;
    #10;
    sb_push("misal_flag_3", 32'd1);
    sb_pop_check({31'd0, o_misaligned});
    read_expect("misal_inst_3", 10'h003, 32'h00108113);
    i_addr = 10'h008;
    #10;
    sb_push("aligned_flag_8", 32'd0);
    sb_pop_check({31'd0, o_misaligned});

    // Write to the top word: old value before the edge, new value after.
    @(negedge i_clk);
    i_addr  = 10'h3FC;
    i_we    = 1'b1;
    i_waddr = 10'h3FC;
    i_wdata = 32'hdeadbeef;
    #1;
    sb_push("wr_top_before", 32'h00000000);
    sb_pop_check(o_inst);
    @(posedge i_clk);
    #1;
    i_we = 1'b0;
    sb_push("wr_top_after", 32'hdeadbeef);
    sb_pop_check(o_inst);
    read_expect("wr_top_readback", 10'h3FC, 32'hdeadbeef);

    // Byte-offset bits of the write address are ignored.
    write_word(10'h023, 32'h0badf00d);
    read_expect("wr_lsb_ignored", 10'h020, 32'h0badf00d);
    read_expect("wr_neighbour", 10'h024, 32'h00000000);

    // Overwrite a boot word, then reset with no clock edge involved.
    write_word(10'h004, 32'h12345678);
    read_expect("ovw_w1", 10'h004, 32'h12345678);
    @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    sb_push("async_rst_w1", 32'h00108193);
    sb_pop_check(o_inst);
    read_expect("async_rst_top", 10'h3FC, 32'h00000000);
    read_expect("async_rst_w8", 10'h020, 32'h00000000);

    // Writes are blocked while reset is held, even with clock edges.
    @(negedge i_clk);
    i_we    = 1'b1;
    i_waddr = 10'h010;
    i_wdata = 32'hffffffff;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    i_we    = 1'b0;
    i_rst_n = 1'b1;
    read_expect("wr_in_rst_w4", 10'h010, 32'h00000000);

    // Same-word read and write: no bypass.
    @(negedge i_clk);
    i_addr  = 10'h00C;
    i_we    = 1'b1;
    i_waddr = 10'h00C;
    i_wdata = 32'ha5a5a5a5;
    #1;
    sb_push("same_word_before", 32'hfe218ae3);
    sb_pop_check(o_inst);
    @(posedge i_clk);
    #1;
    i_we = 1'b0;
    sb_push("same_word_after", 32'ha5a5a5a5);
    sb_pop_check(o_inst);
    read_expect("same_word_w2", 10'h008, 32'h00310233);

    if (sb_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
